// File: rtl/branch_predict_unit.sv
// Branch predict unit: direct-mapped BTB with 2-bit saturating counters on the
// fetch side, conditional-branch resolution plus table training on the EX side,
// and wrapping performance counters for resolved and mispredicted branches.
module branch_predict_unit #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  if_pc,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  input  logic             ex_valid,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_rs1_data,
  input  logic [XLEN-1:0]  ex_rs2_data,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  output logic             branch_taken,
  output logic             mispredict,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             illegal_br,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  // Table lives in flops so that reset can clear every entry at once.
  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [XLEN-1:0]  r_target [ENTRIES];
  logic [1:0]       r_cnt    [ENTRIES];

  logic [IDX_W-1:0] w_if_idx;
  logic [TAG_W-1:0] w_if_tag;
  logic             w_if_hit;
  logic [IDX_W-1:0] w_ex_idx;
  logic [TAG_W-1:0] w_ex_tag;
  logic             w_ex_hit;
  logic             w_eq;
  logic             w_lt;
  logic             w_ltu;
  logic             w_cond;
  logic             w_bad_f3;
  logic             w_train;
  logic [XLEN-1:0]  w_br_target;
  logic [XLEN-1:0]  w_fall_thru;

  assign w_if_idx = if_pc[IDX_W+1:2];
  assign w_if_tag = if_pc[XLEN-1:IDX_W+2];
  assign w_ex_idx = ex_pc[IDX_W+1:2];
  assign w_ex_tag = ex_pc[XLEN-1:IDX_W+2];

  // Fetch-side lookup; reads the table as it stands, with no bypass from EX.
  always_comb begin
    w_if_hit    = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    pred_taken  = w_if_hit && r_cnt[w_if_idx][1];
    pred_target = pred_taken ? r_target[w_if_idx] : (if_pc + XLEN'(4));
  end

  // EX-side resolve: condition evaluation, mispredict and redirect target.
  always_comb begin
    w_eq        = (ex_rs1_data == ex_rs2_data);
    w_lt        = ($signed(ex_rs1_data) < $signed(ex_rs2_data));
    w_ltu       = (ex_rs1_data < ex_rs2_data);
    w_br_target = ex_pc + ex_imm;
    w_fall_thru = ex_pc + XLEN'(4);
    w_bad_f3    = (ex_funct3 == 3'b010) || (ex_funct3 == 3'b011);
    w_cond      = 1'b0;
    case (ex_funct3)
      3'b000:  w_cond = w_eq;
      3'b001:  w_cond = !w_eq;
      3'b100:  w_cond = w_lt;
      3'b101:  w_cond = !w_lt;
      3'b110:  w_cond = w_ltu;
      3'b111:  w_cond = !w_ltu;
      default: w_cond = 1'b0;
    endcase
    illegal_br   = ex_valid && w_bad_f3;
    w_train      = ex_valid && !w_bad_f3;
    branch_taken = w_train && w_cond;
    mispredict   = w_train && ((branch_taken != ex_pred_taken) ||
                               (branch_taken && (ex_pred_target != w_br_target)));
    redirect_pc  = branch_taken ? w_br_target : w_fall_thru;
    w_ex_hit     = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
  end

  // Table training: counters move on a hit, a taken miss allocates as weakly taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_cnt[i]    <= 2'b01;
      end
    end else if (w_train) begin
      if (w_ex_hit) begin
        if (branch_taken) begin
          r_target[w_ex_idx] <= w_br_target;
          if (r_cnt[w_ex_idx] != 2'b11) r_cnt[w_ex_idx] <= r_cnt[w_ex_idx] + 2'b01;
        end else if (r_cnt[w_ex_idx] != 2'b00) begin
          r_cnt[w_ex_idx] <= r_cnt[w_ex_idx] - 2'b01;
        end
      end else if (branch_taken) begin
        r_valid[w_ex_idx]  <= 1'b1;
        r_tag[w_ex_idx]    <= w_ex_tag;
        r_target[w_ex_idx] <= w_br_target;
        r_cnt[w_ex_idx]    <= 2'b10;
      end
    end
  end

  // Performance counters; both wrap naturally at their width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (w_train) begin
      stat_branches <= stat_branches + CNT_W'(1);
      if (mispredict) stat_mispredicts <= stat_mispredicts + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: a reference model computes expected outputs
// when stimulus is driven, queues them, and they are popped and compared once
// the combinational outputs have settled.
module tb_branch_predict_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1_data;
  logic [31:0] ex_rs2_data;
  logic [31:0] ex_imm;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        branch_taken;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        illegal_br;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  branch_predict_unit dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_funct3(ex_funct3),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .branch_taken(branch_taken), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .illegal_br(illegal_br),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pt;
    logic [31:0] ptgt;
    logic        tk;
    logic        mp;
    logic [31:0] redir;
    logic        ill;
    logic [31:0] sb;
    logic [31:0] sm;
  } exp_t;

  exp_t sb_q[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference model of the table and counters.
  logic        m_valid [64];
  logic [23:0] m_tag   [64];
  logic [31:0] m_tgt   [64];
  logic [1:0]  m_cnt   [64];
  logic [31:0] m_b, m_m;

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_cnt[i] = 2'b01;
    end
    m_b = '0; m_m = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // One cycle: drive, predict, compare after settling, clock, train the model.
  task automatic step(input logic [31:0] a_if, input logic a_v, input logic [31:0] a_pc,
                      input logic [2:0] a_f3, input logic [31:0] a_rs1, input logic [31:0] a_rs2,
                      input logic [31:0] a_imm, input logic a_pt, input logic [31:0] a_ptgt);
    exp_t e, g;
    logic [5:0]  fi, ei;
    logic        hit, cond, ill, tk, mp;
    logic [31:0] tgt;
    fi  = a_if[7:2];
    hit = m_valid[fi] && (m_tag[fi] == a_if[31:8]);
    e.pt   = hit && (m_cnt[fi] >= 2'b10);
    e.ptgt = e.pt ? m_tgt[fi] : a_if + 32'd4;
    ill = a_v && (a_f3 == 3'b010 || a_f3 == 3'b011);
    case (a_f3)
      3'b000:  cond = (a_rs1 == a_rs2);
      3'b001:  cond = (a_rs1 != a_rs2);
      3'b100:  cond = ($signed(a_rs1) <  $signed(a_rs2));
      3'b101:  cond = ($signed(a_rs1) >= $signed(a_rs2));
      3'b110:  cond = (a_rs1 <  a_rs2);
      3'b111:  cond = (a_rs1 >= a_rs2);
      default: cond = 1'b0;
    endcase
    tk  = a_v && !ill && cond;
    tgt = a_pc + a_imm;
    mp  = a_v && !ill && ((tk != a_pt) || (tk && a_ptgt != tgt));
    e.tk = tk; e.mp = mp; e.ill = ill;
    e.redir = tk ? tgt : a_pc + 32'd4;
    e.sb = m_b; e.sm = m_m;
    sb_q.push_back(e);

    if_pc = a_if; ex_valid = a_v; ex_pc = a_pc; ex_funct3 = a_f3;
    ex_rs1_data = a_rs1; ex_rs2_data = a_rs2; ex_imm = a_imm;
    ex_pred_taken = a_pt; ex_pred_target = a_ptgt;
    #2;
    g = sb_q.pop_front();
    chk("pred_taken",  {31'd0, pred_taken},   {31'd0, g.pt});
    chk("pred_target", pred_target,           g.ptgt);
    chk("br_taken",    {31'd0, branch_taken}, {31'd0, g.tk});
    chk("mispredict",  {31'd0, mispredict},   {31'd0, g.mp});
    chk("redirect_pc", redirect_pc,           g.redir);
    chk("illegal_br",  {31'd0, illegal_br},   {31'd0, g.ill});
    chk("stat_br",     stat_branches,         g.sb);
    chk("stat_mp",     stat_mispredicts,      g.sm);

    @(posedge clk);
    if (a_v && !ill) begin
      ei = a_pc[7:2];
      if (m_valid[ei] && m_tag[ei] == a_pc[31:8]) begin
        if (tk) begin
          m_tgt[ei] = tgt;
          if (m_cnt[ei] != 2'b11) m_cnt[ei] = m_cnt[ei] + 2'b01;
        end else if (m_cnt[ei] != 2'b00) begin
          m_cnt[ei] = m_cnt[ei] - 2'b01;
        end
      end else if (tk) begin
        m_valid[ei] = 1'b1; m_tag[ei] = a_pc[31:8]; m_tgt[ei] = tgt; m_cnt[ei] = 2'b10;
      end
      m_b = m_b + 1;
      if (mp) m_m = m_m + 1;
    end
    #1;
  endtask

  task automatic idle(input logic [31:0] a_if);
    step(a_if, 1'b0, 32'h0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] r_pc, r_a, r_b, r_imm;
    logic [2:0]  r_f3;
    logic        r_pt;
    model_reset();
    rst_n = 1'b0; if_pc = 32'h100; ex_valid = 1'b0; ex_pc = '0; ex_funct3 = '0;
    ex_rs1_data = '0; ex_rs2_data = '0; ex_imm = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
    #2;
    chk("rst_pred_taken",  {31'd0, pred_taken}, 32'd0);
    chk("rst_pred_target", pred_target,         32'h104);
    chk("rst_stat_br",     stat_branches,       32'd0);
    for (int i = 0; i < 4; i++) begin
      if_pc = $urandom;
      #1;
      chk("rst_rand_pt",   {31'd0, pred_taken}, 32'd0);
      chk("rst_rand_ptgt", pred_target,         if_pc + 32'd4);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // First taken BEQ allocates, next cycle predicts taken
    step(32'h100, 1'b1, 32'h100, 3'b000, 32'd5, 32'd5, 32'h20, 1'b0, 32'h0);
    idle(32'h100);
    // Saturation, then two not-taken
    for (int i = 0; i < 3; i++)
      step(32'h100, 1'b1, 32'h100, 3'b000, 32'd5, 32'd5, 32'h20, 1'b1, 32'h120);
    step(32'h100, 1'b1, 32'h100, 3'b000, 32'd5, 32'd6, 32'h20, 1'b1, 32'h120);
    idle(32'h100);
    step(32'h100, 1'b1, 32'h100, 3'b000, 32'd5, 32'd6, 32'h20, 1'b1, 32'h120);
    idle(32'h100);

    // Signedness, all predicted taken to the real target
    step(32'h400, 1'b1, 32'h400, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b1, 32'h410);
    step(32'h400, 1'b1, 32'h400, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b1, 32'h410);
    step(32'h400, 1'b1, 32'h400, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b1, 32'h410);
    step(32'h400, 1'b1, 32'h400, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b1, 32'h410);

    // Aliasing: retrain 0x100, then 0x200 evicts it; same-cycle lookup sees old entry
    step(32'h100, 1'b1, 32'h100, 3'b001, 32'd1, 32'd2, 32'h20, 1'b0, 32'h0);
    step(32'h100, 1'b1, 32'h200, 3'b000, 32'd7, 32'd7, 32'h40, 1'b0, 32'h0);
    idle(32'h100);
    idle(32'h200);

    // Wrap of targets around the address space
    step(32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 3'b000, 32'd0, 32'd0, 32'h8, 1'b0, 32'h0);
    idle(32'hFFFF_FFFC);

    // Illegal funct3 leaves stats and table alone
    step(32'h300, 1'b1, 32'h300, 3'b010, 32'd1, 32'd1, 32'h8, 1'b0, 32'h0);
    step(32'h300, 1'b1, 32'h300, 3'b011, 32'd1, 32'd2, 32'h8, 1'b1, 32'h308);
    idle(32'h300);

    // Random mix over a small set of aliasing PCs
    for (int i = 0; i < 60; i++) begin
      r_pc  = 32'h100 + ({28'd0, 4'($urandom_range(0, 7))} << 2) + ({31'd0, 1'($urandom_range(0, 1))} << 8);
      r_a   = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3));
      r_b   = 32'($urandom_range(0, 3));
      r_imm = 32'($urandom_range(0, 63)) << 2;
      r_f3  = 3'($urandom_range(0, 7));
      r_pt  = 1'($urandom_range(0, 1));
      step(r_pc, 1'($urandom_range(0, 3) != 0), r_pc, r_f3, r_a, r_b, r_imm, r_pt,
           ($urandom_range(0, 1) != 0) ? r_pc + r_imm : r_pc + 32'd4);
    end

    // Async reset mid-cycle after retraining 0x200
    step(32'h200, 1'b1, 32'h200, 3'b000, 32'd1, 32'd1, 32'h40, 1'b0, 32'h0);
    step(32'h200, 1'b1, 32'h200, 3'b000, 32'd1, 32'd1, 32'h40, 1'b0, 32'h0);
    if_pc = 32'h200; ex_valid = 1'b0;
    #1;
    chk("pre_rst_pt", {31'd0, pred_taken}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_pt",  {31'd0, pred_taken}, 32'd0);
    chk("async_rst_sb",  stat_branches,       32'd0);
    chk("async_rst_sm",  stat_mispredicts,    32'd0);
    model_reset();
    // A taken branch across an edge held in reset must not train
    ex_valid = 1'b1; ex_pc = 32'h300; ex_funct3 = 3'b000;
    ex_rs1_data = 32'd3; ex_rs2_data = 32'd3; ex_imm = 32'h10;
    @(posedge clk); #1;
    chk("rst_edge_sb", stat_branches, 32'd0);
    rst_n = 1'b1;
    idle(32'h300);
    idle(32'h200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
